// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative RV32M multiply/divide unit with handshake and flush
module riscv_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   b_mag;
  logic                neg_main;
  logic                neg_rem;
  logic [DATA_W-1:0]   res_q;

  // request decode: signedness, magnitudes and the divide special cases
  logic              accept, is_div, sign_a_en, sign_b_en, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [DATA_W-1:0] a_abs, b_abs, special_res;

  // acc holds {upper, lower}: product high/low for multiply, remainder/quotient for divide
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W+1:0]   div_trial;
  logic [2*DATA_W-1:0] div_next;

  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix, fix_res;

  assign accept    = in_valid & (state == IDLE) & ~kill;
  assign is_div    = funct3[2];
  assign sign_a_en = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign sign_b_en = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign a_neg     = sign_a_en & op_a[DATA_W-1];
  assign b_neg     = sign_b_en & op_b[DATA_W-1];
  assign a_abs     = a_neg ? -op_a : op_a;
  assign b_abs     = b_neg ? -op_b : op_b;
  assign div_zero  = is_div & (op_b == '0);
  assign div_ovf   = is_div & ~funct3[0] & (op_a == MIN_VAL) & (op_b == '1);
  assign special   = div_zero | div_ovf;

  // special results bypass the iteration entirely
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_next  = {mul_sum, acc[DATA_W-1:1]};
  assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_mag};

  // restoring step: keep the shifted remainder when the trial subtraction borrows
  always_comb begin
    div_next = '0;
    if (div_trial[DATA_W+1]) div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    else                     div_next = {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  end

  assign quo_raw  = acc[DATA_W-1:0];
  assign rem_raw  = acc[2*DATA_W-1:DATA_W];
  assign prod_fix = neg_main ? -acc : acc;
  assign quo_fix  = neg_main ? -quo_raw : quo_raw;
  assign rem_fix  = neg_rem ? -rem_raw : rem_raw;

  // output word selection after sign correction
  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; kill returns to IDLE from any active state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: begin
        if (kill)                  state_nx = IDLE;
        else if (cnt == CNT_LAST)  state_nx = FIX;
      end
      FIX:  state_nx = kill ? IDLE : DONE;
      DONE: if (kill || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath registers: latch on accept, iterate in CALC, resolve in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      tag_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      b_mag    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= funct3;
          tag_q    <= tag_in;
          cnt      <= '0;
          acc      <= {{DATA_W{1'b0}}, a_abs};
          b_mag    <= b_abs;
          neg_main <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          if (special) res_q <= special_res;
        end
        CALC: if (!kill) begin
          acc <= op_q[2] ? div_next : mul_next;
          if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
        end
        FIX: if (!kill) res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - self-checking bench for riscv_muldiv_unit at 32 and 16 bits
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv32, iv16;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  tag_in;
  logic        kill, out_ready;

  logic        ir32, ov32, busy32;
  logic [31:0] res32;
  logic [4:0]  tag32;
  logic        ir16, ov16, busy16;
  logic [15:0] res16;
  logic [4:0]  tag16;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t q32[$];
  exp_t q16[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vt[11];

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.DATA_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .kill(kill), .out_valid(ov32),
    .out_ready(out_ready), .result(res32), .tag_out(tag32), .busy(busy32)
  );

  riscv_muldiv_unit #(.DATA_W(16), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .funct3(funct3),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .tag_in(tag_in), .kill(kill), .out_valid(ov16),
    .out_ready(out_ready), .result(res16), .tag_out(tag16), .busy(busy16)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // reference model built on native wide arithmetic
  function automatic logic [31:0] ref_op(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask, ua, ub, r;
    longint      sa, sb, sp, smin;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = a[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb   = b[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    smin = -($signed(64'd1 << (w - 1)));
    r    = '0;
    case (f)
      3'd0: r = (ua * ub) & mask;
      3'd1: begin sp = sa * sb; r = 64'(sp >>> w) & mask; end
      3'd2: begin sp = sa * $signed(ub); r = 64'(sp >>> w) & mask; end
      3'd3: r = ((ua * ub) >> w) & mask;
      3'd4: begin
        if (ub == 0)                     r = mask;
        else if (sa == smin && sb == -1) r = ua;
        else begin sp = sa / sb; r = 64'(sp) & mask; end
      end
      3'd5: r = (ub == 0) ? mask : (ua / ub);
      3'd6: begin
        if (ub == 0)                     r = ua;
        else if (sa == smin && sb == -1) r = '0;
        else begin sp = sa % sb; r = 64'(sp) & mask; end
      end
      default: r = (ub == 0) ? ua : (ua % ub);
    endcase
    return r[31:0];
  endfunction

  // latency in edges after the accept edge; special cases resolve on the accept edge itself
  function automatic int exp_lat(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [31:0] mask, minv;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    minv = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
    if (f[2] && (((b & mask) == 0) || (!f[0] && ((a & mask) == minv) && ((b & mask) == mask))))
      return 0;
    return w + 1;
  endfunction

  // scoreboard monitors: compare on every output handshake
  always @(negedge clk) begin
    if (reset && ov32 && out_ready) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out32: result %h tag %0d with empty scoreboard", res32, tag32);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("result32", res32, e.res);
        chk("tag32", 32'(tag32), 32'(e.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && ov16 && out_ready) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out16: result %h tag %0d with empty scoreboard", res16, tag16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("result16", 32'(res16), e.res);
        chk("tag16", 32'(tag16), 32'(e.tag));
      end
    end
  end

  // all drive tasks are entered and left 1 time unit after a rising edge
  task automatic issue(int sel, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                       logic [4:0] t, logic [31:0] e, bit push);
    int n = 0;
    while (!(sel != 0 ? ir16 : ir32) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'(n), 32'd0);
    funct3 = f; op_a = a; op_b = b; tag_in = t;
    if (sel != 0) iv16 = 1'b1; else iv32 = 1'b1;
    if (push) begin
      if (sel != 0) q16.push_back(exp_t'{e, t});
      else          q32.push_back(exp_t'{e, t});
    end
    @(posedge clk); #1;
    iv32 = 1'b0; iv16 = 1'b0;
    op_a = ~a; op_b = ~b; funct3 = ~f; tag_in = ~t;
  endtask

  task automatic wait_done(int sel, int lat_req, string name);
    int lat = 0;
    while (!(sel != 0 ? ov16 : ov32) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk(name, 32'(lat), 32'(lat_req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  f;
    logic [31:0] a, b, e;
    logic [31:0] held_res;

    vt[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
    vt[1]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF, 33};
    vt[2]  = '{3'b011, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'h0000_0006, 33};
    vt[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
    vt[4]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 33};
    vt[5]  = '{3'b101, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'h7FFF_FFFC, 33};
    vt[6]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h0000_0001, 33};
    vt[7]  = '{3'b101, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 0};
    vt[8]  = '{3'b110, 32'd5,          32'd0,         5'd9,  32'h0000_0005, 0};
    vt[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0};
    vt[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 0};

    reset = 1'b0; iv32 = 1'b0; iv16 = 1'b0; kill = 1'b0; out_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir32), 32'd1);
    chk("rst_out_valid", 32'(ov32), 32'd0);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_result", res32, 32'd0);
    chk("rst_tag", 32'(tag32), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      issue(0, vt[i].f, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp, 1'b1);
      wait_done(0, vt[i].lat, $sformatf("latency_vec%0d", i));
    end

    // backpressure: DONE holds result, tag and blocks new requests
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(0, 3'b000, 32'd9, 32'd11, 5'd21, 32'd99, 1'b1);
    wait_done(0, 33, "latency_bp");
    held_res = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(ov32), 32'd1);
      chk("bp_result", res32, held_res);
      chk("bp_tag", 32'(tag32), 32'd21);
      chk("bp_in_ready", 32'(ir32), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_busy", 32'(busy32), 32'd0);
    chk("bp_release_in_ready", 32'(ir32), 32'd1);

    // kill has priority over a request in IDLE
    funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; iv32 = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; kill = 1'b0;
    chk("kill_idle_busy", 32'(busy32), 32'd0);

    // kill in the middle of the iteration
    issue(0, 3'b000, 32'd123, 32'd456, 5'd12, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 32'(busy32), 32'd0);
    chk("kill_in_ready", 32'(ir32), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    chk("kill_no_out_valid", 32'(seen), 32'd0);
    issue(0, 3'b000, 32'd3, 32'd4, 5'd13, 32'd12, 1'b1);
    wait_done(0, 33, "latency_after_kill");

    // asynchronous reset in the middle of the iteration
    @(posedge clk); #1;
    issue(0, 3'b100, 32'd1000, 32'd7, 5'd14, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov32), 32'd0);
    chk("midrst_in_ready", 32'(ir32), 32'd1);
    chk("midrst_busy", 32'(busy32), 32'd0);
    chk("midrst_result", res32, 32'd0);
    chk("midrst_tag", 32'(tag32), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    chk("midrst_no_out_valid", 32'(seen), 32'd0);

    // 16-bit instance: directed MULHSU then a mixed random sweep
    issue(1, 3'b010, 32'h8000, 32'hFFFF, 5'd15, 32'h8000, 1'b1);
    wait_done(1, 17, "latency16_mulhsu");
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom & 32'hFFFF;
      b = $urandom & 32'hFFFF;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000; b = 32'hFFFF; end
        default: ;
      endcase
      e = ref_op(16, f, a, b);
      issue(1, f, a, b, 5'(i), e, 1'b1);
      wait_done(1, exp_lat(16, f, a, b), "latency16_rand");
    end

    // 32-bit random sweep
    for (int i = 0; i < 20; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      e = ref_op(32, f, a, b);
      issue(0, f, a, b, 5'(i + 7), e, 1'b1);
      wait_done(0, exp_lat(32, f, a, b), "latency32_rand");
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard32_drained", 32'(q32.size()), 32'd0);
    chk("scoreboard16_drained", 32'(q16.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
